// File: rtl/reg_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_pkg
//  Description : Shared widths, register-file constants and the MUL/DIV
//                result FIFO entry type for the register writeback scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_wb_pkg;

    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int NUM_REGS = 32;

    // Architectural zero register; writes to it are discarded.
    localparam logic [AW-1:0] c_x0 = '0;

    // One buffered MUL/DIV result waiting for the write port.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } md_entry_t;

endpackage
`default_nettype wire

// File: rtl/md_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : md_result_fifo
//  Description : Small circular FIFO with a valid/ready push side and a
//                pop/empty read side. Head data is presented combinationally.
//                DEPTH must be a power of two and at least 2 so the pointers
//                wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         PUSH_VALID,
    input  logic [W-1:0] PUSH_DATA,
    output logic         PUSH_READY,
    input  logic         POP,
    output logic [W-1:0] POP_DATA,
    output logic         EMPTY
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign PUSH_READY = (r_count != c_full);
    assign EMPTY      = (r_count == '0);
    assign POP_DATA   = r_mem[r_rd_ptr];
    assign w_push     = PUSH_VALID & PUSH_READY;
    assign w_pop      = POP & ~EMPTY;

    // Storage array: written on an accepted push, no reset needed.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= PUSH_DATA;
        end
    end

    // Pointer and occupancy tracking; push+pop together leaves count unchanged.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_scheduler
//  Description : Arbitrates the single register-file write port between the
//                in-order pipeline writeback (always wins) and buffered
//                out-of-order MUL/DIV results. Tracks registers with pending
//                MUL/DIV results and raises a combinational decode stall.
//                Optional macro REG_WB_PERF_CNT_EN adds STALL_CNT and
//                CONFLICT_CNT performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_scheduler
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = reg_wb_pkg::AW,
    parameter int DW    = reg_wb_pkg::DW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          PIPE_WE,
    input  logic [AW-1:0] PIPE_ADDR,
    input  logic [DW-1:0] PIPE_DATA,
    input  logic          MD_VALID,
    input  logic [AW-1:0] MD_ADDR,
    input  logic [DW-1:0] MD_DATA,
    output logic          MD_READY,
    input  logic          ISSUE_MD,
    input  logic [AW-1:0] ISSUE_RD,
    input  logic [AW-1:0] DEC_RS1,
    input  logic [AW-1:0] DEC_RS2,
    input  logic [AW-1:0] DEC_RD,
    input  logic          DEC_USE_RS2,
    output logic          STALL,
    output logic          WRITE,
    output logic [AW-1:0] ADDRW,
    output logic [DW-1:0] IN
`ifdef REG_WB_PERF_CNT_EN
    ,
    output logic [31:0]   STALL_CNT,
    output logic [31:0]   CONFLICT_CNT
`endif
);

    md_entry_t w_push_entry;
    md_entry_t w_head_entry;
    logic      w_fifo_empty;
    logic      w_fifo_push;
    logic      w_pipe_wr;
    logic      w_pop;
    logic      r_wb_is_md;

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Results destined for x0 are handshaken but never stored.
    assign w_push_entry.addr = MD_ADDR;
    assign w_push_entry.data = MD_DATA;
    assign w_fifo_push       = MD_VALID & (MD_ADDR != c_x0);

    // Pipe writes to x0 do not claim the port, letting the FIFO drain.
    assign w_pipe_wr = PIPE_WE & (PIPE_ADDR != c_x0);
    assign w_pop     = ~w_fifo_empty & ~w_pipe_wr;

    md_result_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(md_entry_t))
    ) u_md_fifo (
        .CLK        (CLK),
        .RESET      (RESET),
        .PUSH_VALID (w_fifo_push),
        .PUSH_DATA  (w_push_entry),
        .PUSH_READY (MD_READY),
        .POP        (w_pop),
        .POP_DATA   (w_head_entry),
        .EMPTY      (w_fifo_empty)
    );

    // Write-port arbiter: pipe first, then FIFO head, else hold address/data.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            WRITE      <= 1'b0;
            ADDRW      <= '0;
            IN         <= '0;
            r_wb_is_md <= 1'b0;
        end else if (w_pipe_wr) begin
            WRITE      <= 1'b1;
            ADDRW      <= PIPE_ADDR;
            IN         <= PIPE_DATA;
            r_wb_is_md <= 1'b0;
        end else if (!w_fifo_empty) begin
            WRITE      <= 1'b1;
            ADDRW      <= w_head_entry.addr;
            IN         <= w_head_entry.data;
            r_wb_is_md <= 1'b1;
        end else begin
            WRITE      <= 1'b0;
            r_wb_is_md <= 1'b0;
        end
    end

    // Scoreboard next state: clear on MUL/DIV commit, set on issue (set wins).
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_set[i] = ISSUE_MD & (ISSUE_RD == AW'(i));
            w_clr[i] = WRITE & r_wb_is_md & (ADDRW == AW'(i));
        end
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard state, discarded on reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // x0 never reads as busy, so x0 operands cannot stall.
    assign STALL = r_busy[DEC_RS1]
                 | (DEC_USE_RS2 & r_busy[DEC_RS2])
                 | r_busy[DEC_RD];

`ifdef REG_WB_PERF_CNT_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            STALL_CNT    <= '0;
            CONFLICT_CNT <= '0;
        end else begin
            if (STALL) begin
                STALL_CNT <= STALL_CNT + 32'd1;
            end
            if (PIPE_WE && !w_fifo_empty) begin
                CONFLICT_CNT <= CONFLICT_CNT + 32'd1;
            end
        end
    end
`else
    // Performance counters not built.
`endif

endmodule
`default_nettype wire
